// File: rtl/divider_pkg.sv
// Shared operation codes and decode helpers for the divide/remainder unit.
// Op codes match the ALU decode so CPU, ALU and divider agree.
package divider_pkg;

   localparam logic [4:0] OP_DIVU = 5'd20;
   localparam logic [4:0] OP_DIVS = 5'd21;
   localparam logic [4:0] OP_REMU = 5'd22;
   localparam logic [4:0] OP_REMS = 5'd23;

   function automatic logic op_valid(input logic [4:0] o);
      return (o == OP_DIVU) || (o == OP_DIVS) || (o == OP_REMU) || (o == OP_REMS);
   endfunction

   function automatic logic op_signed(input logic [4:0] o);
      return (o == OP_DIVS) || (o == OP_REMS);
   endfunction

   function automatic logic op_rem(input logic [4:0] o);
      return (o == OP_REMU) || (o == OP_REMS);
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] r,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] r_next,
   output logic [WIDTH-1:0] q_next
);

   logic [WIDTH:0]   r_sh;
   logic [WIDTH+1:0] r_diff;
   logic             fits;
   logic             unused_diff_msb;

   // r_sh carries one extra bit so the compare/subtract cannot overflow.
   assign r_sh            = {r, q[WIDTH-1]};
   assign r_diff          = {1'b0, r_sh} - {2'b00, d};
   assign fits            = ~r_diff[WIDTH+1];
   assign unused_diff_msb = r_diff[WIDTH];
   assign r_next          = fits ? r_diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
   assign q_next          = {q[WIDTH-2:0], fits};

endmodule

// File: rtl/divider.sv
// Sequential 32-bit divide/remainder unit: restoring iteration on magnitudes,
// sign fix-up in the final step. Result and flags hold until the next op.
module divider
   import divider_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter bit ZERO_FAST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [7:0]       op,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] c,
   output logic             is_zero,
   output logic             is_negative
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_FIX} state_t;

   state_t           state, state_next;
   logic [4:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q, r_q, q_q, d_q;
   logic             neg_q, neg_r, dz_q;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] step_r, step_q, abs_a, abs_b;
   logic [WIDTH-1:0] fin_q, fin_r, res;
   logic             fin_nq, fin_nr, is_sgn, is_rem, accept;
   logic             unused_op_hi;

   assign unused_op_hi = ^op[7:5];
   assign is_sgn       = op_signed(op_q);
   assign is_rem       = op_rem(op_q);
   assign accept       = (state == S_IDLE) && start && op_valid(op[4:0]);
   assign busy         = (state != S_IDLE);
   assign done         = (state == S_FIX);

   div_step #(.WIDTH(WIDTH)) u_step (
      .r      (r_q),
      .q      (q_q),
      .d      (d_q),
      .r_next (step_r),
      .q_next (step_q)
   );

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: if (accept) state_next = S_LOAD;
         S_LOAD: state_next = (ZERO_FAST && (b_q == '0)) ? S_FIX : S_RUN;
         S_RUN:  if (count == '0) state_next = S_FIX;
         S_FIX:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Final quotient/remainder come from the last RUN step, or straight from
   // LOAD on the fast divide-by-zero path.
   always_comb begin
      abs_a = (is_sgn && a_q[WIDTH-1]) ? -a_q : a_q;
      abs_b = (is_sgn && b_q[WIDTH-1]) ? -b_q : b_q;
      if (state == S_LOAD) begin
         fin_q  = '1;
         fin_r  = abs_a;
         fin_nq = 1'b0;
         fin_nr = is_sgn && a_q[WIDTH-1];
      end else begin
         fin_q  = step_q;
         fin_r  = step_r;
         fin_nq = neg_q && !dz_q;
         fin_nr = neg_r;
      end
      if (is_rem) res = fin_nr ? -fin_r : fin_r;
      else        res = fin_nq ? -fin_q : fin_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         r_q         <= '0;
         q_q         <= '0;
         d_q         <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         dz_q        <= 1'b0;
         count       <= '0;
         c           <= '0;
         is_zero     <= 1'b1;
         is_negative <= 1'b0;
      end else begin
         state <= state_next;
         if (accept) begin
            op_q <= op[4:0];
            a_q  <= a;
            b_q  <= b;
         end
         if (state == S_LOAD) begin
            r_q   <= '0;
            q_q   <= abs_a;
            d_q   <= abs_b;
            neg_q <= is_sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            neg_r <= is_sgn && a_q[WIDTH-1];
            dz_q  <= (b_q == '0);
            count <= CW'(WIDTH - 1);
         end
         if (state == S_RUN) begin
            r_q   <= step_r;
            q_q   <= step_q;
            count <= count - CW'(1);
         end
         if (state_next == S_FIX) begin
            c           <= res;
            is_zero     <= (res == '0);
            is_negative <= res[WIDTH-1];
         end
      end
   end

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: two instances (fast and full-latency
// divide-by-zero) share stimulus; each has its own expected-result queue.
module tb_divider;

   logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic [7:0]  op = '0;
   logic        busy_f, done_f, zero_f, neg_f;
   logic        busy_s, done_s, zero_s, neg_s;
   logic [31:0] c_f, c_s;
   int          cyc = 0, checks = 0, failures = 0;

   typedef struct {logic [31:0] c; int cyc;} exp_t;
   exp_t q_f[$], q_s[$];

   divider #(.WIDTH(32), .ZERO_FAST(1'b1)) dut_f (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .op(op),
      .busy(busy_f), .done(done_f), .c(c_f), .is_zero(zero_f), .is_negative(neg_f));

   divider #(.WIDTH(32), .ZERO_FAST(1'b0)) dut_s (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .op(op),
      .busy(busy_s), .done(done_s), .c(c_s), .is_zero(zero_s), .is_negative(neg_s));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h cycle=%0d", name, act, exp, cyc);
      end
   endtask

   // Reference: plain integer arithmetic with the unit's zero/overflow rules.
   function automatic logic [31:0] ref_model(input logic [31:0] x, input logic [31:0] y,
                                             input logic [4:0] o);
      int sx, sy;
      logic ovf;
      sx  = x;
      sy  = y;
      ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
      case (o)
         5'd20:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
         5'd22:   return (y == 0) ? x : x % y;
         5'd21:   return (y == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sx / sy));
         default: return (y == 0) ? x : (ovf ? 32'h0 : 32'(sx % sy));
      endcase
   endfunction

   always @(negedge clk) begin : mon_f
      exp_t e;
      if (done_f) begin
         if (q_f.size() == 0) begin
            checks++; failures++;
            $display("FAIL done_fast_unexpected actual=1 required=0 cycle=%0d", cyc);
         end else begin
            e = q_f.pop_front();
            check("c_fast", c_f, e.c);
            check("zero_fast", zero_f, e.c == 0);
            check("neg_fast", neg_f, e.c[31]);
            check("latency_fast", cyc, e.cyc);
         end
      end
   end

   always @(negedge clk) begin : mon_s
      exp_t e;
      if (done_s) begin
         if (q_s.size() == 0) begin
            checks++; failures++;
            $display("FAIL done_slow_unexpected actual=1 required=0 cycle=%0d", cyc);
         end else begin
            e = q_s.pop_front();
            check("c_slow", c_s, e.c);
            check("zero_slow", zero_s, e.c == 0);
            check("neg_slow", neg_s, e.c[31]);
            check("latency_slow", cyc, e.cyc);
         end
      end
   end

   task automatic issue(input logic [31:0] ta, input logic [31:0] tb, input logic [7:0] top);
      exp_t e;
      a = ta; b = tb; op = top; start = 1'b1;
      if (top[4:0] inside {5'd20, 5'd21, 5'd22, 5'd23}) begin
         e.c   = ref_model(ta, tb, top[4:0]);
         e.cyc = cyc + 34;
         q_s.push_back(e);
         if (tb == 0) e.cyc = cyc + 2;
         q_f.push_back(e);
      end
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((q_f.size() != 0 || q_s.size() != 0) && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      if (q_f.size() != 0 || q_s.size() != 0) begin
         checks++; failures++;
         $display("FAIL done_timeout actual=%0d,%0d required=0,0 cycle=%0d", q_f.size(), q_s.size(), cyc);
         q_f.delete(); q_s.delete();
      end
      check("busy_after_fast", busy_f, 0);
      check("busy_after_slow", busy_s, 0);
   endtask

   logic [31:0] da [10] = '{32'd100, 32'd100, 32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'd100,
                            32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FF9C};
   logic [31:0] db [10] = '{32'd7, 32'd7, 32'd7, 32'd7, 32'hFFFF_FFF9,
                            32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
   logic [7:0]  dop[10] = '{8'd20, 8'd22, 8'd21, 8'd23, 8'd23, 8'd20, 8'd22, 8'd21, 8'd23, 8'hF7};

   initial begin
      int t0;
      logic [31:0] ra, rb;
      logic [7:0]  rop;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check("rst_busy", busy_f, 0);
      check("rst_done", done_f, 0);
      check("rst_c", c_f, 0);
      check("rst_zero", zero_f, 1);
      check("rst_neg", neg_f, 0);
      check("rst_c_slow", c_s, 0);

      for (int i = 0; i < 10; i++) begin
         issue(da[i], db[i], dop[i]);
         wait_idle();
      end

      // Starts during a running op must be ignored.
      t0 = cyc;
      issue(32'd100, 32'd7, 8'd20);
      while (cyc < t0 + 5) begin @(posedge clk); #1; end
      a = 32'd5; b = 32'd1; op = 8'd21; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      while (cyc < t0 + 20) begin @(posedge clk); #1; end
      a = 32'd77; b = 32'd0; op = 8'd22; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_idle();

      // Unsupported op code: nothing happens.
      issue(32'd1, 32'd1, 8'd12);
      for (int i = 0; i < 3; i++) begin
         check("busy_invalid_op", busy_f, 0);
         @(posedge clk); #1;
      end

      // Reset mid-operation abandons it without a done pulse.
      t0 = cyc;
      issue(32'd1000, 32'd3, 8'd20);
      while (cyc < t0 + 10) begin @(posedge clk); #1; end
      reset = 1'b1;
      q_f.delete(); q_s.delete();
      @(posedge clk); #1 reset = 1'b0;
      check("midrst_busy", busy_f, 0);
      check("midrst_c", c_f, 0);
      check("midrst_zero", zero_f, 1);
      check("midrst_busy_slow", busy_s, 0);
      repeat (40) @(posedge clk);
      #1;
      issue(32'd9, 32'd3, 8'd20);
      wait_idle();

      for (int i = 0; i < 40; i++) begin
         ra  = $urandom;
         rop = 8'($urandom_range(0, 7) * 32 + 20 + $urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 15));
            2:       rb = $urandom;
            default: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
         endcase
         if ($urandom_range(0, 3) == 0) rb = -rb;
         issue(ra, rb, rop);
         wait_idle();
      end

      check("queue_fast_empty", q_f.size(), 0);
      check("queue_slow_empty", q_s.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
